// File: rtl/cpu.sv
// Five-stage pipelined MIPS-subset CPU with on-chip memories.
// Ports: clk_i (clock), rst_i (async active-low reset), start_i (run enable).

package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_MUL = 6'b011000;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_MUL = 3'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } if_id_t;

    typedef struct packed {
        logic        we;
        logic        mem_rd;
        logic        mem_wr;
        logic        use_imm;
        logic [2:0]  alu_op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
    } id_ex_t;

    typedef struct packed {
        logic        we;
        logic        mem_rd;
        logic        mem_wr;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] st_data;
    } ex_mem_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  dest;
        logic [31:0] wdata;
    } mem_wb_t;

endpackage

// Program counter register; clears to 0 on reset.
module cpu_pc (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_d,
    output logic [31:0] pc_o
);
    logic [31:0] pc_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) pc_q <= '0;
        else        pc_q <= pc_d;
    end

    assign pc_o = pc_q;
endmodule

// Register file: two combinational reads, one write, write-through bypass.
module cpu_regfile (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_a_i,
    input  logic [4:0]  raddr_b_i,
    output logic [31:0] rdata_a_o,
    output logic [31:0] rdata_b_o
);
    logic [31:0] register [0:31];

    always_ff @(posedge clk_i) begin
        if (we_i && waddr_i != 5'd0) register[waddr_i] <= wdata_i;
    end

    always_comb begin
        rdata_a_o = register[raddr_a_i];
        if (raddr_a_i == 5'd0)
            rdata_a_o = '0;
        else if (we_i && waddr_i == raddr_a_i)
            rdata_a_o = wdata_i;
    end

    always_comb begin
        rdata_b_o = register[raddr_b_i];
        if (raddr_b_i == 5'd0)
            rdata_b_o = '0;
        else if (we_i && waddr_i == raddr_b_i)
            rdata_b_o = wdata_i;
    end
endmodule

// Instruction memory, 256 words; the write port exists for loading.
module cpu_imem (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [7:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [7:0]  raddr_i,
    output logic [31:0] rdata_o
);
    logic [31:0] memory [0:255];

    always_ff @(posedge clk_i) begin
        if (we_i) memory[waddr_i] <= wdata_i;
    end

    assign rdata_o = memory[raddr_i];
endmodule

// Data memory, 32 words, combinational read, not touched by reset.
module cpu_dmem (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [4:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o
);
    logic [31:0] memory [0:31];

    always_ff @(posedge clk_i) begin
        if (we_i) memory[addr_i] <= wdata_i;
    end

    assign rdata_o = memory[addr_i];
endmodule

module cpu
    import cpu_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i
);
    logic [31:0] pc;
    logic [31:0] pc_d;
    logic [31:0] imem_rdata;
    logic [31:0] dmem_rdata;

    if_id_t  if_id_q,  if_id_d;
    id_ex_t  id_ex_q,  id_ex_d;
    ex_mem_t ex_mem_q, ex_mem_d;
    mem_wb_t mem_wb_q, mem_wb_d;

    logic [5:0]  id_op;
    logic [5:0]  id_fn;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [31:0] id_imm;
    logic [31:0] rf_a;
    logic [31:0] rf_b;

    logic        dec_we;
    logic        dec_mem_rd;
    logic        dec_mem_wr;
    logic        dec_use_imm;
    logic        dec_beq;
    logic [2:0]  dec_alu;
    logic [4:0]  dec_dest;

    logic        load_use;
    logic        br_ex_hz;
    logic        br_mem_hz;
    logic        stall;
    logic        id_hold;
    logic        taken;
    logic [31:0] br_a;
    logic [31:0] br_b;
    logic [31:0] br_target;

    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic [31:0] alu_b;
    logic [31:0] alu_y;

    logic unused_shamt;

    cpu_pc PC (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .pc_d  (pc_d),
        .pc_o  (pc)
    );

    cpu_imem Instruction_Memory (
        .clk_i   (clk_i),
        .we_i    (1'b0),
        .waddr_i (8'd0),
        .wdata_i (32'd0),
        .raddr_i (pc[9:2]),
        .rdata_o (imem_rdata)
    );

    cpu_regfile Registers (
        .clk_i     (clk_i),
        .we_i      (mem_wb_q.we),
        .waddr_i   (mem_wb_q.dest),
        .wdata_i   (mem_wb_q.wdata),
        .raddr_a_i (id_rs),
        .raddr_b_i (id_rt),
        .rdata_a_o (rf_a),
        .rdata_b_o (rf_b)
    );

    cpu_dmem Data_Memory (
        .clk_i   (clk_i),
        .we_i    (ex_mem_q.mem_wr),
        .addr_i  (ex_mem_q.alu[6:2]),
        .wdata_i (ex_mem_q.st_data),
        .rdata_o (dmem_rdata)
    );

    // ---------------- ID: decode ----------------
    assign id_op  = if_id_q.instr[31:26];
    assign id_rs  = if_id_q.instr[25:21];
    assign id_rt  = if_id_q.instr[20:16];
    assign id_rd  = if_id_q.instr[15:11];
    assign id_fn  = if_id_q.instr[5:0];
    assign id_imm = {{16{if_id_q.instr[15]}}, if_id_q.instr[15:0]};
    assign unused_shamt = ^if_id_q.instr[10:6];

    always_comb begin
        dec_we      = 1'b0;
        dec_mem_rd  = 1'b0;
        dec_mem_wr  = 1'b0;
        dec_use_imm = 1'b0;
        dec_beq     = 1'b0;
        dec_alu     = ALU_ADD;
        dec_dest    = id_rt;
        unique case (1'b1)
            (id_op == OP_RTYPE): begin
                dec_dest = id_rd;
                unique case (1'b1)
                    (id_fn == FN_ADD): begin dec_we = 1'b1; dec_alu = ALU_ADD; end
                    (id_fn == FN_SUB): begin dec_we = 1'b1; dec_alu = ALU_SUB; end
                    (id_fn == FN_AND): begin dec_we = 1'b1; dec_alu = ALU_AND; end
                    (id_fn == FN_OR):  begin dec_we = 1'b1; dec_alu = ALU_OR;  end
                    (id_fn == FN_MUL): begin dec_we = 1'b1; dec_alu = ALU_MUL; end
                    default: ;
                endcase
            end
            (id_op == OP_ADDI): begin
                dec_we      = 1'b1;
                dec_use_imm = 1'b1;
            end
            (id_op == OP_LW): begin
                dec_we      = 1'b1;
                dec_mem_rd  = 1'b1;
                dec_use_imm = 1'b1;
            end
            (id_op == OP_SW): begin
                dec_mem_wr  = 1'b1;
                dec_use_imm = 1'b1;
            end
            (id_op == OP_BEQ): dec_beq = 1'b1;
            default: ;
        endcase
    end

    // ---------------- hazards and branch ----------------
    always_comb begin
        load_use = id_ex_q.mem_rd &&
                   (id_ex_q.rt == id_rs || id_ex_q.rt == id_rt);

        // beq compares in ID, so a value still in EX (or a load in MEM)
        // is not yet available to it.
        br_ex_hz = dec_beq && id_ex_q.we && id_ex_q.dest != 5'd0 &&
                   (id_ex_q.dest == id_rs || id_ex_q.dest == id_rt);
        br_mem_hz = dec_beq && ex_mem_q.mem_rd && ex_mem_q.we &&
                    ex_mem_q.dest != 5'd0 &&
                    (ex_mem_q.dest == id_rs || ex_mem_q.dest == id_rt);
        stall = load_use || br_ex_hz || br_mem_hz;

        // A beq must not be dropped while fetch is paused: keep it in ID.
        id_hold = stall || (!start_i && dec_beq);

        br_a = rf_a;
        if (ex_mem_q.we && !ex_mem_q.mem_rd && ex_mem_q.dest != 5'd0 &&
            ex_mem_q.dest == id_rs)
            br_a = ex_mem_q.alu;
        br_b = rf_b;
        if (ex_mem_q.we && !ex_mem_q.mem_rd && ex_mem_q.dest != 5'd0 &&
            ex_mem_q.dest == id_rt)
            br_b = ex_mem_q.alu;

        taken     = dec_beq && (br_a == br_b);
        br_target = if_id_q.pc4 + {id_imm[29:0], 2'b00};
    end

    // ---------------- IF / PC next ----------------
    always_comb begin
        pc_d = pc + 32'd4;
        if (!start_i || stall)
            pc_d = pc;
        else if (taken)
            pc_d = br_target;
    end

    always_comb begin
        if_id_d.instr = imem_rdata;
        if_id_d.pc4   = pc + 32'd4;
        if (id_hold)
            if_id_d = if_id_q;
        else if (taken || !start_i)
            if_id_d = '0;
    end

    always_comb begin
        id_ex_d = '0;
        if (!id_hold) begin
            id_ex_d.we      = dec_we;
            id_ex_d.mem_rd  = dec_mem_rd;
            id_ex_d.mem_wr  = dec_mem_wr;
            id_ex_d.use_imm = dec_use_imm;
            id_ex_d.alu_op  = dec_alu;
            id_ex_d.rs      = id_rs;
            id_ex_d.rt      = id_rt;
            id_ex_d.dest    = dec_dest;
            id_ex_d.rs_val  = rf_a;
            id_ex_d.rt_val  = rf_b;
            id_ex_d.imm     = id_imm;
        end
    end

    // ---------------- EX ----------------
    always_comb begin
        fwd_a = id_ex_q.rs_val;
        if (ex_mem_q.we && ex_mem_q.dest != 5'd0 &&
            ex_mem_q.dest == id_ex_q.rs)
            fwd_a = ex_mem_q.alu;
        else if (mem_wb_q.we && mem_wb_q.dest != 5'd0 &&
                 mem_wb_q.dest == id_ex_q.rs)
            fwd_a = mem_wb_q.wdata;

        fwd_b = id_ex_q.rt_val;
        if (ex_mem_q.we && ex_mem_q.dest != 5'd0 &&
            ex_mem_q.dest == id_ex_q.rt)
            fwd_b = ex_mem_q.alu;
        else if (mem_wb_q.we && mem_wb_q.dest != 5'd0 &&
                 mem_wb_q.dest == id_ex_q.rt)
            fwd_b = mem_wb_q.wdata;

        alu_b = id_ex_q.use_imm ? id_ex_q.imm : fwd_b;

        unique case (id_ex_q.alu_op)
            ALU_SUB: alu_y = fwd_a - alu_b;
            ALU_AND: alu_y = fwd_a & alu_b;
            ALU_OR:  alu_y = fwd_a | alu_b;
            ALU_MUL: alu_y = fwd_a * alu_b;
            default: alu_y = fwd_a + alu_b;
        endcase

        ex_mem_d.we      = id_ex_q.we;
        ex_mem_d.mem_rd  = id_ex_q.mem_rd;
        ex_mem_d.mem_wr  = id_ex_q.mem_wr;
        ex_mem_d.dest    = id_ex_q.dest;
        ex_mem_d.alu     = alu_y;
        ex_mem_d.st_data = fwd_b;
    end

    // ---------------- MEM ----------------
    always_comb begin
        mem_wb_d.we    = ex_mem_q.we;
        mem_wb_d.dest  = ex_mem_q.dest;
        mem_wb_d.wdata = ex_mem_q.mem_rd ? dmem_rdata : ex_mem_q.alu;
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            if_id_q  <= '0;
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            if_id_q  <= if_id_d;
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end
endmodule

// File: tb/tb_cpu.sv
// Bench for cpu: directed programs plus random programs checked
// against an instruction-level interpreter of the ISA.

module tb_cpu;

    logic clk_i   = 1'b0;
    logic rst_i   = 1'b0;
    logic start_i = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] prog     [0:255];
    logic [31:0] init_reg [0:31];
    logic [31:0] init_mem [0:31];
    logic [31:0] m_reg    [0:31];
    logic [31:0] m_mem    [0:31];

    cpu dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [5:0] fn,
            input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return {6'b000000, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op,
            input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic clear_state();
        for (int i = 0; i < 256; i++) prog[i] = '0;
        for (int i = 0; i < 32; i++) begin
            init_reg[i] = '0;
            init_mem[i] = '0;
        end
    endtask

    task automatic start_run();
        rst_i   = 1'b0;
        start_i = 1'b0;
        @(negedge clk_i);
        for (int i = 0; i < 256; i++)
            dut.Instruction_Memory.memory[i] = prog[i];
        for (int i = 0; i < 32; i++) begin
            dut.Registers.register[i] = init_reg[i];
            dut.Data_Memory.memory[i] = init_mem[i];
        end
        @(negedge clk_i);
        rst_i   = 1'b1;
        start_i = 1'b1;
    endtask

    task automatic run_cycles(input int n, output int holds);
        logic [31:0] prev;
        holds = 0;
        prev  = dut.PC.pc_o;
        repeat (n) begin
            @(posedge clk_i);
            #1;
            if (dut.PC.pc_o == prev) holds++;
            prev = dut.PC.pc_o;
        end
    endtask

    // Sequential ISA interpreter over the words of prog[0..n-1].
    task automatic model_run(input int n);
        logic [31:0] pc, nxt, ins, a, b, sx, ea;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd;
        int steps;
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = init_reg[i];
            m_mem[i] = init_mem[i];
        end
        m_reg[0] = '0;
        pc = 0;
        steps = 0;
        while (pc < 32'(n * 4) && steps < 2000) begin
            ins = prog[pc / 4 % 256];
            op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
            rd = ins[15:11]; fn = ins[5:0];
            a = m_reg[rs]; b = m_reg[rt];
            sx = {{16{ins[15]}}, ins[15:0]};
            ea = a + sx;
            nxt = pc + 4;
            case (op)
                6'b000000: begin
                    case (fn)
                        6'b100000: if (rd != 0) m_reg[rd] = a + b;
                        6'b100010: if (rd != 0) m_reg[rd] = a - b;
                        6'b100100: if (rd != 0) m_reg[rd] = a & b;
                        6'b100101: if (rd != 0) m_reg[rd] = a | b;
                        6'b011000: if (rd != 0) m_reg[rd] = a * b;
                        default: ;
                    endcase
                end
                6'b001000: if (rt != 0) m_reg[rt] = ea;
                6'b100011: if (rt != 0) m_reg[rt] = m_mem[ea / 4 % 32];
                6'b101011: m_mem[ea / 4 % 32] = b;
                6'b000100: if (a == b) nxt = pc + 4 + sx * 4;
                default: ;
            endcase
            pc = nxt;
            steps++;
        end
    endtask

    function automatic logic [31:0] rand_ins();
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 10))
            0: return r_ins(6'b100000, rd, rs, rt);
            1: return r_ins(6'b100010, rd, rs, rt);
            2: return r_ins(6'b100100, rd, rs, rt);
            3: return r_ins(6'b100101, rd, rs, rt);
            4: return r_ins(6'b011000, rd, rs, rt);
            5: begin
                imm = 16'($urandom_range(0, 40)) - 16'd8;
                return i_ins(6'b001000, rt, rs, imm);
            end
            6: begin
                imm = 16'($urandom_range(0, 80)) - 16'd16;
                return i_ins(6'b100011, rt, rs, imm);
            end
            7: begin
                imm = 16'($urandom_range(0, 80)) - 16'd16;
                return i_ins(6'b101011, rt, rs, imm);
            end
            8: return i_ins(6'b000100, rt, rs, 16'($urandom_range(0, 3)));
            9: return {6'b111111, 26'($urandom)};
            default: return r_ins(6'b000010, rd, rs, rt);
        endcase
    endfunction

    int h;
    int found;
    int nw;

    initial begin
        // ---- reset and free-running PC over an all-nop program ----
        clear_state();
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_pc", dut.PC.pc_o, 32'd0);
        start_run();
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk_i);
            #1;
            chk($sformatf("pc_seq%0d", k), dut.PC.pc_o, 32'(4 * k));
        end
        run_cycles(10, h);
        for (int i = 0; i < 32; i++)
            chk($sformatf("nop_r%0d", i), dut.Registers.register[i], 32'd0);
        @(negedge clk_i);
        start_i = 1'b0;
        run_cycles(3, h);
        chk("start0_holds", 32'(h), 32'd3);

        // ---- ALU with back-to-back forwarding ----
        clear_state();
        prog[0] = i_ins(6'b001000, 5'd8, 5'd0, 16'd5);
        prog[1] = i_ins(6'b001000, 5'd9, 5'd0, 16'd3);
        prog[2] = r_ins(6'b100000, 5'd10, 5'd8, 5'd9);
        prog[3] = r_ins(6'b100010, 5'd11, 5'd8, 5'd9);
        prog[4] = r_ins(6'b011000, 5'd12, 5'd8, 5'd9);
        prog[5] = r_ins(6'b100100, 5'd13, 5'd8, 5'd9);
        prog[6] = r_ins(6'b100101, 5'd14, 5'd8, 5'd9);
        start_run();
        run_cycles(20, h);
        chk("alu_holds", 32'(h), 32'd0);
        chk("alu_r10", dut.Registers.register[10], 32'd8);
        chk("alu_r11", dut.Registers.register[11], 32'd2);
        chk("alu_r12", dut.Registers.register[12], 32'd15);
        chk("alu_r13", dut.Registers.register[13], 32'd1);
        chk("alu_r14", dut.Registers.register[14], 32'd7);

        // ---- load-use ----
        clear_state();
        prog[0] = i_ins(6'b001000, 5'd8, 5'd0, 16'd7);
        prog[1] = i_ins(6'b101011, 5'd8, 5'd0, 16'd4);
        prog[2] = i_ins(6'b100011, 5'd9, 5'd0, 16'd4);
        prog[3] = r_ins(6'b100000, 5'd10, 5'd9, 5'd9);
        start_run();
        run_cycles(20, h);
        chk("lu_holds", 32'(h), 32'd1);
        chk("lu_dmem1", dut.Data_Memory.memory[1], 32'd7);
        chk("lu_r10", dut.Registers.register[10], 32'd14);

        // ---- branch taken / not taken ----
        for (int t = 0; t < 2; t++) begin
            clear_state();
            prog[0] = i_ins(6'b001000, 5'd8, 5'd0, 16'd1);
            prog[1] = i_ins(6'b001000, 5'd9, 5'd0, (t == 0) ? 16'd1 : 16'd2);
            prog[2] = i_ins(6'b000100, 5'd9, 5'd8, 16'd1);
            prog[3] = i_ins(6'b001000, 5'd10, 5'd0, 16'd9);
            prog[4] = i_ins(6'b001000, 5'd11, 5'd0, 16'd4);
            start_run();
            run_cycles(20, h);
            chk($sformatf("br%0d_r10", t), dut.Registers.register[10],
                (t == 0) ? 32'd0 : 32'd9);
            chk($sformatf("br%0d_r11", t), dut.Registers.register[11], 32'd4);
        end

        // ---- r0 protection ----
        clear_state();
        init_reg[8] = 32'hdead_beef;
        prog[0] = i_ins(6'b001000, 5'd0, 5'd0, 16'd5);
        prog[1] = r_ins(6'b100000, 5'd8, 5'd0, 5'd0);
        start_run();
        run_cycles(15, h);
        chk("r0_r0", dut.Registers.register[0], 32'd0);
        chk("r0_r8", dut.Registers.register[8], 32'd0);

        // ---- reset asserted mid-run at PC=24 ----
        clear_state();
        for (int k = 0; k < 8; k++)
            prog[k] = i_ins(6'b001000, 5'(k + 1), 5'd0, 16'(k + 1));
        start_run();
        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            @(posedge clk_i);
            #1;
            if (dut.PC.pc_o == 32'd24) found = 1;
        end
        chk("mid_pc24_seen", 32'(found), 32'd1);
        rst_i = 1'b0;
        #1;
        chk("mid_pc_now", dut.PC.pc_o, 32'd0);
        repeat (4) @(posedge clk_i);
        #1;
        chk("mid_pc_held", dut.PC.pc_o, 32'd0);
        for (int k = 1; k <= 8; k++)
            chk($sformatf("mid_r%0d", k), dut.Registers.register[k],
                (k <= 2) ? 32'(k) : 32'd0);

        // ---- random programs against the interpreter ----
        for (int t = 0; t < 20; t++) begin
            clear_state();
            nw = 30;
            for (int i = 1; i < 32; i++) init_reg[i] = 32'($urandom_range(0, 3));
            for (int i = 0; i < 32; i++) init_mem[i] = $urandom;
            for (int i = 0; i < nw; i++) prog[i] = rand_ins();
            model_run(nw);
            start_run();
            run_cycles(3 * nw + 20, h);
            for (int i = 0; i < 32; i++)
                chk($sformatf("rnd%0d_r%0d", t, i),
                    dut.Registers.register[i], m_reg[i]);
            for (int i = 0; i < 32; i++)
                chk($sformatf("rnd%0d_m%0d", t, i),
                    dut.Data_Memory.memory[i], m_mem[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
